// File: rtl/display_scan.sv
// Multiplexed 7-segment display scanner with per-slot anti-ghosting blanking,
// frame-synchronous value commit and optional leading-zero suppression.
module display_scan #(
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV = 27000,
   parameter int unsigned BLANK_CYC   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*N_DIGITS-1:0]   valor,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    load,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [N_DIGITS-1:0]     an,
   output logic                    frame_done
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned VW = 4 * N_DIGITS;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 tick_c, wrap_c;

   logic [VW-1:0]        act_val, pend_val;
   logic [N_DIGITS-1:0]  act_dp, pend_dp;
   logic                 pend_valid;

   logic [3:0]           nibs [N_DIGITS];
   logic [N_DIGITS-1:0]  zero_from;
   logic                 run_zero;
   logic [3:0]           cur_nib;
   logic                 cur_dp;
   logic                 suppress_c;

   logic [N_DIGITS-1:0]  an_d;
   logic [6:0]           seg_d;
   logic                 dp_d;
   logic                 fd_d;

   // Hex nibble to segment pattern {g,f,e,d,c,b,a}, active-high
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign tick_c = (cnt_q == CW'(REFRESH_DIV - 1));
   assign wrap_c = tick_c && (idx_q == IW'(N_DIGITS - 1));

   // Prescaler and digit index advance
   always_comb begin
      cnt_d = tick_c ? '0 : cnt_q + CW'(1);
      idx_d = idx_q;
      if (wrap_c) begin
         idx_d = '0;
      end else if (tick_c) begin
         idx_d = idx_q + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   // Double-buffered value: pending is only committed at the frame boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         act_val    <= '0;
         act_dp     <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
      end else if (wrap_c) begin
         if (load) begin
            act_val <= valor;
            act_dp  <= dp_in;
         end else if (pend_valid) begin
            act_val <= pend_val;
            act_dp  <= pend_dp;
         end
         pend_valid <= 1'b0;
      end else if (load) begin
         pend_val   <= valor;
         pend_dp    <= dp_in;
         pend_valid <= 1'b1;
      end
   end

   // Active digit selection and leading-zero detection (digit i and above all zero)
   always_comb begin
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         nibs[i] = act_val[4*i +: 4];
      end
      run_zero  = 1'b1;
      zero_from = '0;
      for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
         run_zero     = run_zero && (nibs[i] == 4'h0);
         zero_from[i] = run_zero;
      end
      cur_nib    = nibs[idx_q];
      cur_dp     = act_dp[idx_q];
      suppress_c = blank_lz && (idx_q != '0) && zero_from[idx_q];
   end

   // Slot phase state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BLANK;
      end else begin
         state_q <= state_d;
      end
   end

   // Next phase and next registered outputs
   always_comb begin
      state_d = state_q;
      an_d    = '1;
      seg_d   = '1;
      dp_d    = 1'b1;
      fd_d    = wrap_c;
      state_d = (cnt_d < CW'(BLANK_CYC)) ? ST_BLANK : ST_SHOW;
      case (state_q)
         ST_SHOW: begin
            an_d[idx_q] = 1'b0;
            if (!suppress_c) begin
               seg_d = ~hex7(cur_nib);
               dp_d  = ~cur_dp;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an         <= '1;
         seg        <= '1;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         an         <= an_d;
         seg        <= seg_d;
         dp         <= dp_d;
         frame_done <= fd_d;
      end
   end

endmodule

// File: tb/tb_display_scan.sv
// Randomized and directed bench for display_scan against a cycle-count based
// reference model (slot/frame position derived arithmetically from edges since reset).
module tb_display_scan;

   localparam int unsigned ND    = 4;
   localparam int unsigned RD    = 8;
   localparam int unsigned BC    = 2;
   localparam int unsigned FRAME = ND * RD;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] valor;
   logic [3:0]  dp_in;
   logic        load;
   logic        blank_lz;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   int passed = 0;
   int total  = 0;

   // Reference model state
   int          m_p;
   logic [15:0] m_act, m_pend;
   logic [3:0]  m_dpa, m_pdp;
   logic        m_pv;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic        e_fd;

   display_scan #(.N_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
      .clk(clk), .rst(rst), .valor(valor), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] font(input int v);
      logic [6:0] f [16];
      f = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return f[v & 15];
   endfunction

   // One clock edge: predict the outputs from the pre-edge position and value, then apply commit rules
   task automatic step();
      int cnt, idx;
      logic [15:0] above;
      @(posedge clk);
      if (rst) begin
         m_p = 0; m_act = '0; m_pend = '0; m_dpa = '0; m_pdp = '0; m_pv = 1'b0;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      end else begin
         cnt = m_p % RD;
         idx = (m_p / RD) % ND;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         if (cnt >= BC) begin
            e_an[idx] = 1'b0;
            above = m_act >> (4 * idx);
            if (!(blank_lz && idx > 0 && above == 16'h0)) begin
               e_seg = ~font(int'(above & 16'hF));
               e_dp  = ~m_dpa[idx];
            end
         end
         e_fd = (m_p % FRAME == FRAME - 1);
         if (m_p % FRAME == FRAME - 1) begin
            if (load) begin m_act = valor; m_dpa = dp_in; end
            else if (m_pv) begin m_act = m_pend; m_dpa = m_pdp; end
            m_pv = 1'b0;
         end else if (load) begin
            m_pend = valor; m_pdp = dp_in; m_pv = 1'b1;
         end
         m_p++;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; valor = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0})
            $display("FAIL reset cyc=%0d got an=%b seg=%b dp=%b fd=%b", i, an, seg, dp, frame_done);
         else passed++;
      end
   endtask

   task automatic test_release();
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         total++;
         if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
            $display("FAIL release_model k=%0d got %b_%b_%b_%b want %b_%b_%b_%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
         else passed++;
         if (k == 1 || k == 2 || k == 9 || k == 3 || k == 8 || k == 11) begin
            total++;
            if ((k <= 2 || k == 9) ? (an !== 4'b1111) :
                (k == 11) ? ({an, seg} !== {4'b1101, 7'b1000000}) :
                            ({an, seg} !== {4'b1110, 7'b1000000}))
               $display("FAIL release_const k=%0d got an=%b seg=%b", k, an, seg);
            else passed++;
         end
      end
   endtask

   task automatic test_digits();
      logic [6:0] cap [4];
      logic [6:0] want [4];
      logic       seen_fd;
      want = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
      cap = '{7'hxx, 7'hxx, 7'hxx, 7'hxx};
      seen_fd = 1'b0;
      blank_lz = 1'b0; valor = 16'h12AF; dp_in = 4'h0; load = 1'b1;
      for (int k = 0; k < 80; k++) begin
         step();
         load = 1'b0;
         total++;
         if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
            $display("FAIL digits_model k=%0d got %b_%b_%b_%b want %b_%b_%b_%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
         else passed++;
         if (seen_fd) for (int i = 0; i < 4; i++) if (an[i] == 1'b0) cap[i] = seg;
         if (frame_done) seen_fd = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (cap[i] !== want[i]) $display("FAIL digits_const d%0d got seg=%b want %b", i, cap[i], want[i]);
         else passed++;
      end
   endtask

   task automatic test_lz();
      logic [6:0] cap [4];
      logic [3:0] lit;
      logic       seen_fd;
      cap = '{7'hxx, 7'hxx, 7'hxx, 7'hxx};
      lit = 4'h0; seen_fd = 1'b0;
      blank_lz = 1'b1; valor = 16'h0005; dp_in = 4'hE; load = 1'b1;
      for (int k = 0; k < 80; k++) begin
         step();
         load = 1'b0;
         total++;
         if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
            $display("FAIL lz_model k=%0d got %b_%b_%b_%b want %b_%b_%b_%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
         else passed++;
         if (seen_fd) for (int i = 0; i < 4; i++) if (an[i] == 1'b0) begin cap[i] = seg; lit[i] = ~dp; end
         if (frame_done) seen_fd = 1'b1;
      end
      total++;
      if ({cap[3], cap[2], cap[1], cap[0], lit} !== {7'h7F, 7'h7F, 7'h7F, 7'b0010010, 4'h0})
         $display("FAIL lz_const got d3=%b d2=%b d1=%b d0=%b dp_lit=%b", cap[3], cap[2], cap[1], cap[0], lit);
      else passed++;
   endtask

   task automatic test_last_wins();
      int ones, twos;
      ones = 0; twos = 0;
      blank_lz = 1'b0; dp_in = 4'h0;
      for (int k = 0; k < 40 && (m_p % FRAME) != 2; k++) step();
      for (int k = 0; k < 72; k++) begin
         load = (k == 1 || k == 9);
         valor = (k == 1) ? 16'h1111 : 16'h2222;
         step();
         total++;
         if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
            $display("FAIL lastwin_model k=%0d got %b_%b_%b_%b want %b_%b_%b_%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
         else passed++;
         if (an != 4'hF && seg == 7'b1111001) ones++;
         if (an != 4'hF && seg == 7'b0100100) twos++;
      end
      load = 1'b0;
      total++;
      if (ones != 0 || twos == 0) $display("FAIL lastwin_const got ones=%0d twos=%0d want ones=0 twos>0", ones, twos);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int bad;
      bad = 0;
      blank_lz = 1'b0;
      for (int k = 0; k < 40 && m_p != 2 * RD + 3; k++) step();
      valor = 16'h9999; dp_in = 4'hF; load = 1'b1;
      step();
      load = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0})
         $display("FAIL rstmid_blank got an=%b seg=%b dp=%b fd=%b", an, seg, dp, frame_done);
      else passed++;
      for (int k = 0; k < 70; k++) begin
         step();
         total++;
         if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
            $display("FAIL rstmid_model k=%0d got %b_%b_%b_%b want %b_%b_%b_%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
         else passed++;
         if (k == 2 && an !== 4'b1110) bad++;
         if (an != 4'hF && {seg, dp} != {7'b1000000, 1'b1}) bad++;
      end
      total++;
      if (bad != 0) $display("FAIL rstmid_const got bad=%0d want 0", bad);
      else passed++;
   endtask

   task automatic test_frame();
      int last, pulses, badgap, multi;
      last = -1; pulses = 0; badgap = 0; multi = 0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         step();
         if ($countones(~an) > 1) multi++;
         if (frame_done) begin
            if (last >= 0 && k - last != FRAME) badgap++;
            last = k; pulses++;
         end
      end
      total++;
      if (pulses != 3 || badgap != 0 || multi != 0)
         $display("FAIL frame_period got pulses=%0d badgap=%0d multi_an=%0d want 3 0 0", pulses, badgap, multi);
      else passed++;
   endtask

   task automatic test_load_on_commit();
      for (int k = 0; k < 40 && (m_p % FRAME) != FRAME - 1; k++) step();
      valor = 16'hC0DE; dp_in = 4'h5; blank_lz = 1'b0; load = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         load = 1'b0;
         total++;
         if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd})
            $display("FAIL commitload k=%0d got %b_%b_%b_%b want %b_%b_%b_%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
         else passed++;
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 500; k++) begin
         valor = 16'($urandom);
         if ($urandom_range(0, 3) == 0) valor = valor & 16'h00FF;
         dp_in = 4'($urandom);
         load = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
         step();
         total++;
         if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd} || $countones(~an) > 1)
            $display("FAIL random k=%0d got %b_%b_%b_%b want %b_%b_%b_%b", k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
         else passed++;
      end
      load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_release();
      test_digits();
      test_lz();
      test_last_wins();
      test_reset_mid();
      test_frame();
      test_load_on_commit();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
